// File: rtl/uart_rx_parity.sv
// UART receiver: start, 8 data bits MSB first, even parity, stop; 14 clocks per bit.
// Define UART_RX_FRAME_ERR_EN to also reject frames whose stop bit samples low.
module uart_rx_parity #(
  parameter int          CLKS_PER_BIT = 14,
  parameter int          SAMPLE_POINT = 7,
  parameter logic [7:0]  ERR_CHAR     = 8'h3F
) (
  input  logic       clk_3125,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_msg,
  output logic       rx_parity,
  output logic       rx_complete
);

  localparam int CYC_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [7:0]       rx_msg_q, rx_msg_d;
  logic             rx_parity_q, rx_parity_d;
  logic             rx_complete_q, rx_complete_d;
`ifdef UART_RX_FRAME_ERR_EN
  logic             stop_q, stop_d;
`endif

  // cyc_q is the zero-based cycle index within the current bit.
  logic last_cyc;
  logic sample_cyc;
  assign last_cyc   = (cyc_q == CYC_W'(CLKS_PER_BIT - 1));
  assign sample_cyc = (cyc_q == CYC_W'(SAMPLE_POINT - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cyc_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      rx_msg_q      <= 8'h00;
      rx_parity_q   <= 1'b0;
      rx_complete_q <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      stop_q        <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      rx_msg_q      <= rx_msg_d;
      rx_parity_q   <= rx_parity_d;
      rx_complete_q <= rx_complete_d;
`ifdef UART_RX_FRAME_ERR_EN
      stop_q        <= stop_d;
`endif
    end
  end

  // Next-state and datapath.
  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    cyc_d   = last_cyc ? '0 : cyc_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
`ifdef UART_RX_FRAME_ERR_EN
    stop_d  = stop_q;
`endif
    unique case (state_q)
      IDLE: begin
        cyc_d = '0;
        bit_d = '0;
        // The clock that first sees rx low is already cycle 1 of the start bit.
        if (!rx) begin
          state_d = START;
          cyc_d   = CYC_W'(1);
        end
      end
      START: begin
        if (last_cyc) state_d = DATA;
      end
      DATA: begin
        if (sample_cyc) shift_d = {shift_q[6:0], rx};
        if (last_cyc) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (sample_cyc) par_d = rx;
        if (last_cyc)   state_d = STOP;
      end
      STOP: begin
`ifdef UART_RX_FRAME_ERR_EN
        if (sample_cyc) stop_d = rx;
`endif
        if (last_cyc) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cyc_d   = '0;
      end
    endcase
  end

  // Outputs: registered, updated only on the final cycle of the stop bit.
  always_comb begin
    logic frame_ok;
    frame_ok = ((^shift_q) == par_q);
`ifdef UART_RX_FRAME_ERR_EN
    frame_ok = frame_ok && stop_q;
`endif
    rx_complete_d = 1'b0;
    rx_msg_d      = rx_msg_q;
    rx_parity_d   = rx_parity_q;
    if (state_q == STOP && last_cyc) begin
      rx_complete_d = 1'b1;
      rx_parity_d   = par_q;
      rx_msg_d      = frame_ok ? shift_q : ERR_CHAR;
    end
  end

  assign rx_msg      = rx_msg_q;
  assign rx_parity   = rx_parity_q;
  assign rx_complete = rx_complete_q;

endmodule

// File: tb/tb_uart_rx_parity.sv
// Directed bench for uart_rx_parity: drives whole frames bit by bit and checks
// strobe position, held outputs, received byte/parity, and mid-frame reset.
module tb_uart_rx_parity;

  logic       clk_3125 = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rx       = 1'b1;
  logic [7:0] rx_msg;
  logic       rx_parity;
  logic       rx_complete;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_rx_parity dut (
    .clk_3125    (clk_3125),
    .rst_n       (rst_n),
    .rx          (rx),
    .rx_msg      (rx_msg),
    .rx_parity   (rx_parity),
    .rx_complete (rx_complete)
  );

  always #5 clk_3125 = ~clk_3125;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one 154-clock frame; rx changes 1 time unit after each rising edge.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stp,
                            input string tag);
    logic [10:0] bits;
    logic [7:0]  m0;
    logic        p0;
    int strobes, strobe_at, hold_err;
    bits      = {1'b0, data, par, stp};
    m0        = rx_msg;
    p0        = rx_parity;
    strobes   = 0;
    strobe_at = 0;
    hold_err  = 0;
    for (int k = 1; k <= 154; k++) begin
      rx = bits[10 - (k - 1) / 14];
      @(posedge clk_3125);
      #1;
      if (rx_complete === 1'b1) begin
        strobes++;
        strobe_at = k;
      end
      if (k < 154 && (rx_msg !== m0 || rx_parity !== p0)) hold_err++;
    end
    check({tag, "_strobe_count"}, strobes, 1);
    check({tag, "_strobe_cycle"}, strobe_at, 154);
    check({tag, "_held"}, hold_err, 0);
  endtask

  initial begin
    logic [7:0] bytes [10];
    logic [10:0] part;
    int cnt;

    // Reset values.
    repeat (3) @(posedge clk_3125);
    #1;
    check("rst_msg", rx_msg, 8'h00);
    check("rst_parity", rx_parity, 1'b0);
    check("rst_complete", rx_complete, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk_3125);
    #1;

    // 'A' with correct even parity.
    send_frame(8'h41, 1'b0, 1'b1, "a");
    check("a_msg", rx_msg, 8'h41);
    check("a_parity", rx_parity, 1'b0);
    @(posedge clk_3125);
    #1;
    check("a_strobe_drop", rx_complete, 1'b0);

    // 'A' with wrong parity bit.
    send_frame(8'h41, 1'b1, 1'b1, "perr");
    check("perr_msg", rx_msg, 8'h3F);
    check("perr_parity", rx_parity, 1'b1);

    // 'C' has odd weight, so parity 1 is correct.
    send_frame(8'h43, 1'b1, 1'b1, "c");
    check("c_msg", rx_msg, 8'h43);
    check("c_parity", rx_parity, 1'b1);
    rx = 1'b1;
    repeat (4) @(posedge clk_3125);

    // Reset in the middle of a 0x55 frame.
    part = {1'b0, 8'h55, 1'b0, 1'b1};
    for (int k = 1; k <= 60; k++) begin
      rx = part[10 - (k - 1) / 14];
      @(posedge clk_3125);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_msg", rx_msg, 8'h00);
    check("midrst_parity", rx_parity, 1'b0);
    check("midrst_complete", rx_complete, 1'b0);
    rx = 1'b1;
    repeat (3) @(posedge clk_3125);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk_3125);
      #1;
      if (rx_complete === 1'b1) cnt++;
    end
    check("postrst_no_strobe", cnt, 0);
    check("postrst_msg", rx_msg, 8'h00);

    // Ten back-to-back frames, no idle gap.
    bytes = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h80, 8'h01, 8'h7E, 8'h3C, 8'hC3, 8'h42};
    for (int i = 0; i < 10; i++) begin
      send_frame(bytes[i], ^bytes[i], 1'b1, $sformatf("b2b%0d", i));
      check($sformatf("b2b%0d_msg", i), rx_msg, bytes[i]);
      check($sformatf("b2b%0d_parity", i), rx_parity, ^bytes[i]);
    end
    rx = 1'b1;
    repeat (3) @(posedge clk_3125);
    #1;

    // Valid 'A' with the stop bit low.
    send_frame(8'h41, 1'b0, 1'b0, "stop0");
    rx = 1'b1;
`ifdef UART_RX_FRAME_ERR_EN
    check("stop0_msg", rx_msg, 8'h3F);
`else
    check("stop0_msg", rx_msg, 8'h41);
`endif
    check("stop0_parity", rx_parity, 1'b0);
    repeat (20) @(posedge clk_3125);
    #1;
    check("idle_no_strobe", rx_complete, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_parity.md
Name: uart_rx_parity

Overview:
- UART receiver clocked at 3.125 MHz (clk_3125); fixed 14 clocks per bit (~223 kbaud).
- Frame: 11 bits = start(0), 8 data bits MSB first, even-parity bit, stop(1); one frame = 154 clocks.
- Delivers the received byte, the received parity bit, and a one-cycle rx_complete strobe per frame.
- Substitutes '?' (8'h3F) for the byte when parity mismatches.
- Sits between the serial pin and the message/colour-report logic.

Parameters:
- CLKS_PER_BIT, 14, clock cycles per serial bit.
- SAMPLE_POINT, 7, cycle within a bit (1..CLKS_PER_BIT) at which rx is sampled.
- ERR_CHAR, 8'h3F, byte output on parity error.

Ports:
- clk_3125  input  1  3.125 MHz system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  serial data, idle high; synchronous to clk_3125, no resynchronizer.
- rx_msg  output  8  last received byte (or ERR_CHAR); held between frames.
- rx_parity  output  1  parity bit as received in the last frame; held.
- rx_complete  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: rx_msg=8'h00, rx_parity=0, rx_complete=0, state=IDLE, bit/cycle counters=0, shift register=0.
- States:
  - IDLE: the first clock with rx==0 enters START; that clock counts as cycle 1 of the start bit.
  - START: lasts CLKS_PER_BIT cycles; start level is not re-validated.
  - DATA: 8 bits × CLKS_PER_BIT cycles; at SAMPLE_POINT of each bit, shift the sample in as LSB (first bit ends in rx_msg[7], MSB first).
  - PARITY: sample at SAMPLE_POINT into a parity register.
  - STOP: lasts CLKS_PER_BIT cycles. On its last cycle (frame cycle 154):
    - assert rx_complete for exactly that cycle;
    - load rx_parity with the received parity bit;
    - load rx_msg with the byte if (^byte)==parity bit, else ERR_CHAR;
    - return to IDLE.
- Back-to-back frames: the cycle after frame cycle 154, IDLE must already accept a new start bit (no idle gap required). rx_complete therefore pulses exactly every 154 clocks under continuous traffic.
- Outputs change only on the rx_complete cycle; stable otherwise.
- Stop bit level is ignored unless UART_RX_FRAME_ERR_EN is defined.
- Glitch: rx returning high mid-start is not checked; the frame completes regardless.
- Reset mid-frame: immediate return to IDLE with reset values; partial frame discarded, no strobe.

Optional Feature:
- Macro: UART_RX_FRAME_ERR_EN.
- Defined: the stop bit is sampled at SAMPLE_POINT; if it is 0, rx_msg=ERR_CHAR on completion regardless of parity. rx_complete and rx_parity behave as normal.
- Undefined: the stop bit is not sampled and has no effect.

Test Plan:
- Reset: assert rst_n=0 mid-frame -> outputs 0 immediately; after release with rx=1, no rx_complete ever.
- Single frame 'A': bits 0,0,1,0,0,0,0,0,1,0,1 (start, 0x41 MSB first, parity 0, stop) -> rx_complete high only on clock 154; rx_msg=8'h41, rx_parity=0.
- Parity error: 0x41 with parity bit 1 -> rx_msg=8'h3F, rx_parity=1, strobe on clock 154.
- Odd-weight byte 'C' (8'h43, parity 1) correct -> rx_msg=8'h43, rx_parity=1.
- Ten back-to-back frames, no idle gap -> ten strobes spaced exactly 154 clocks; each rx_msg matches its byte; outputs held between strobes.
- With UART_RX_FRAME_ERR_EN: valid 0x41 frame with stop=0 -> rx_msg=8'h3F; without macro -> 8'h41.
